// File: rtl/recon_load_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | recon_load_scheduler: bitstream table, bump allocator and DMA descriptor   |
// | sequencer. Optional flush input under macro RECON_SCHED_FLUSH_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module recon_load_scheduler #(
  parameter int              ADDR_WIDTH         = 34,
  parameter int              DMA_DESC_LEN_WIDTH = 20,
  parameter int              DMA_DESC_TAG_WIDTH = 8,
  parameter int              TABLE_DEPTH        = 16,
  parameter longint unsigned REGION_BASE        = 64'd0,
  parameter longint unsigned REGION_SIZE        = 64'h100_0000,
  parameter int              ALIGN_LOG2         = 12,
  parameter int              CHUNK_LOG2         = 12,
  parameter int              MAX_OUTSTANDING    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef RECON_SCHED_FLUSH_EN
  input  logic                          flush,
`endif
  input  logic                          store_req_valid,
  output logic                          store_req_ready,
  input  logic [7:0]                    store_id,
  input  logic [31:0]                   store_size,
  input  logic                          load_req_valid,
  output logic                          load_req_ready,
  input  logic [7:0]                    load_id,
  output logic [ADDR_WIDTH-1:0]         m_axis_read_desc_addr,
  output logic [DMA_DESC_LEN_WIDTH-1:0] m_axis_read_desc_len,
  output logic [DMA_DESC_TAG_WIDTH-1:0] m_axis_read_desc_tag,
  output logic                          m_axis_read_desc_valid,
  input  logic                          m_axis_read_desc_ready,
  input  logic [DMA_DESC_TAG_WIDTH-1:0] s_axis_read_desc_status_tag,
  input  logic [3:0]                    s_axis_read_desc_status_error,
  input  logic                          s_axis_read_desc_status_valid,
  output logic                          done_valid,
  output logic                          done_op,
  output logic [7:0]                    done_id,
  output logic [1:0]                    done_status,
  output logic [ADDR_WIDTH-1:0]         done_addr,
  output logic                          busy
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_STORE_ALLOC = 3'd1,
    S_LOAD_LOOKUP = 3'd2,
    S_LOAD_ISSUE  = 3'd3,
    S_LOAD_WAIT   = 3'd4,
    S_DONE        = 3'd5
  } state_t;

  localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW    = ((ADDR_WIDTH > 33) ? ADDR_WIDTH : 33) + 1;
  localparam logic [CW-1:0] REGION_END  = CW'(REGION_BASE + REGION_SIZE);
  localparam logic [32:0]   ALIGN_MASK  = 33'((64'd1 << ALIGN_LOG2) - 64'd1);
  localparam logic [31:0]   CHUNK_BYTES = 32'(64'd1 << CHUNK_LOG2);
  localparam logic [1:0]    ST_OK   = 2'd0;
  localparam logic [1:0]    ST_BAD  = 2'd1;
  localparam logic [1:0]    ST_MISS = 2'd2;
  localparam logic [1:0]    ST_ERR  = 2'd3;

  state_t                  state;
  logic                    armed;
  logic                    last_grant_load;
  logic [7:0]              req_id;
  logic [31:0]             req_size;
  logic                    tbl_valid [TABLE_DEPTH];
  logic [ADDR_WIDTH-1:0]   tbl_base  [TABLE_DEPTH];
  logic [31:0]             tbl_size  [TABLE_DEPTH];
  logic [32:0]             tbl_alloc [TABLE_DEPTH];
  logic [ADDR_WIDTH-1:0]   next_free;
  logic [31:0]             remaining;
  logic [OUT_W-1:0]        outstanding;
  logic                    err;

  logic                    flush_req;
  logic                    idle_free;
  logic                    store_fire;
  logic                    load_fire;
  logic                    id_ok;
  logic [IDX_W-1:0]        idx;
  logic [32:0]             aligned;
  logic                    reuse;
  logic                    fits;
  logic                    accept;
  logic                    stat_hit;
  logic [OUT_W-1:0]        outstanding_nx;
  logic                    err_nx;
  logic [31:0]             rem_nx;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic                    unused_ok;

`ifdef RECON_SCHED_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  function automatic logic [31:0] chunk_len(input logic [31:0] rem);
    return (rem < CHUNK_BYTES) ? rem : CHUNK_BYTES;
  endfunction

  // armed keeps both readies low until the first clock after reset release
  assign idle_free       = armed && (state == S_IDLE) && !flush_req;
  assign store_req_ready = idle_free && (!load_req_valid || last_grant_load);
  assign load_req_ready  = idle_free && (!store_req_valid || !last_grant_load);
  assign store_fire      = store_req_valid && store_req_ready;
  assign load_fire       = load_req_valid && load_req_ready;

  assign id_ok   = 32'(req_id) < TABLE_DEPTH;
  assign idx     = req_id[IDX_W-1:0];
  assign aligned = ({1'b0, req_size} + ALIGN_MASK) & ~ALIGN_MASK;
  assign reuse   = tbl_valid[idx] && (aligned <= tbl_alloc[idx]);
  assign fits    = (CW'(next_free) + CW'(aligned)) <= REGION_END;

  assign accept   = m_axis_read_desc_valid && m_axis_read_desc_ready;
  assign stat_hit = s_axis_read_desc_status_valid && (outstanding != '0) &&
                    ((state == S_LOAD_ISSUE) || (state == S_LOAD_WAIT));
  assign err_nx   = err || (stat_hit && (s_axis_read_desc_status_error != 4'd0));
  assign rem_nx   = remaining - 32'(m_axis_read_desc_len);
  assign addr_nx  = m_axis_read_desc_addr + ADDR_WIDTH'(m_axis_read_desc_len);
  assign unused_ok = ^s_axis_read_desc_status_tag;

  always_comb begin
    outstanding_nx = outstanding;
    if (accept && !stat_hit)
      outstanding_nx = outstanding + 1'b1;
    else if (!accept && stat_hit)
      outstanding_nx = outstanding - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= S_IDLE;
      armed                  <= 1'b0;
      last_grant_load        <= 1'b1;
      req_id                 <= '0;
      req_size               <= '0;
      next_free              <= ADDR_WIDTH'(REGION_BASE);
      remaining              <= '0;
      outstanding            <= '0;
      err                    <= 1'b0;
      m_axis_read_desc_addr  <= '0;
      m_axis_read_desc_len   <= '0;
      m_axis_read_desc_tag   <= '0;
      m_axis_read_desc_valid <= 1'b0;
      done_valid             <= 1'b0;
      done_op                <= 1'b0;
      done_id                <= '0;
      done_status            <= '0;
      done_addr              <= '0;
      busy                   <= 1'b0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_base[i]  <= '0;
        tbl_size[i]  <= '0;
        tbl_alloc[i] <= '0;
      end
    end else begin
      armed      <= 1'b1;
      done_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush_req) begin
            for (int i = 0; i < TABLE_DEPTH; i++) tbl_valid[i] <= 1'b0;
            next_free <= ADDR_WIDTH'(REGION_BASE);
          end else if (store_fire) begin
            state           <= S_STORE_ALLOC;
            req_id          <= store_id;
            req_size        <= store_size;
            last_grant_load <= 1'b0;
            busy            <= 1'b1;
          end else if (load_fire) begin
            state           <= S_LOAD_LOOKUP;
            req_id          <= load_id;
            last_grant_load <= 1'b1;
            busy            <= 1'b1;
          end
        end
        S_STORE_ALLOC: begin
          state      <= S_DONE;
          done_valid <= 1'b1;
          done_op    <= 1'b0;
          done_id    <= req_id;
          done_addr  <= '0;
          if (!id_ok) begin
            done_status <= ST_BAD;
          end else if (req_size == 32'd0) begin
            done_status <= ST_ERR;
          end else if (reuse) begin
            tbl_size[idx] <= req_size;
            done_addr     <= tbl_base[idx];
            done_status   <= ST_OK;
          end else if (fits) begin
            tbl_valid[idx] <= 1'b1;
            tbl_base[idx]  <= next_free;
            tbl_size[idx]  <= req_size;
            tbl_alloc[idx] <= aligned;
            next_free      <= next_free + ADDR_WIDTH'(aligned);
            done_addr      <= next_free;
            done_status    <= ST_OK;
          end else begin
            done_status <= ST_MISS;
          end
        end
        S_LOAD_LOOKUP: begin
          done_op   <= 1'b1;
          done_id   <= req_id;
          done_addr <= '0;
          if (!id_ok || !tbl_valid[idx]) begin
            state       <= S_DONE;
            done_valid  <= 1'b1;
            done_status <= id_ok ? ST_MISS : ST_BAD;
          end else begin
            state                  <= S_LOAD_ISSUE;
            remaining              <= tbl_size[idx];
            err                    <= 1'b0;
            done_addr              <= tbl_base[idx];
            m_axis_read_desc_addr  <= tbl_base[idx];
            m_axis_read_desc_len   <= DMA_DESC_LEN_WIDTH'(chunk_len(tbl_size[idx]));
            m_axis_read_desc_tag   <= '0;
            m_axis_read_desc_valid <= 1'b1;
          end
        end
        S_LOAD_ISSUE: begin
          outstanding <= outstanding_nx;
          err         <= err_nx;
          if (accept) begin
            remaining             <= rem_nx;
            m_axis_read_desc_addr <= addr_nx;
            m_axis_read_desc_len  <= DMA_DESC_LEN_WIDTH'(chunk_len(rem_nx));
            m_axis_read_desc_tag  <= m_axis_read_desc_tag + 1'b1;
            if (rem_nx == 32'd0) begin
              m_axis_read_desc_valid <= 1'b0;
              state                  <= S_LOAD_WAIT;
            end else begin
              m_axis_read_desc_valid <= 32'(outstanding_nx) < MAX_OUTSTANDING;
            end
          end else if (!m_axis_read_desc_valid) begin
            // a raised valid is held until accepted; only an idle slot may rise
            m_axis_read_desc_valid <= 32'(outstanding_nx) < MAX_OUTSTANDING;
          end
        end
        S_LOAD_WAIT: begin
          outstanding <= outstanding_nx;
          err         <= err_nx;
          if (outstanding_nx == '0) begin
            state       <= S_DONE;
            done_valid  <= 1'b1;
            done_status <= err_nx ? ST_ERR : ST_OK;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_recon_load_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_recon_load_scheduler: scoreboard bench; instance a uses default params, |
// | instance b a 16 KiB region with one outstanding descriptor.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_recon_load_scheduler;

  typedef struct {
    logic [33:0] addr;
    logic [19:0] len;
    logic [7:0]  tag;
    int          cyc;
  } desc_t;

  typedef struct {
    logic        op;
    logic [7:0]  id;
    logic [1:0]  status;
    logic [33:0] addr;
    logic        chk_addr;
    int          cyc;
  } done_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  desc_t       dq[$];
  done_t       oq[$];

  logic        store_req_valid = 1'b0;
  logic [7:0]  store_id = '0;
  logic [31:0] store_size = '0;
  logic        load_req_valid = 1'b0;
  logic [7:0]  load_id = '0;
  logic        desc_ready = 1'b0;
  logic [7:0]  st_tag = '0;
  logic [3:0]  st_err = '0;
  logic        st_valid = 1'b0;

  logic        a_sr, a_lr, a_dv, a_ov, a_op, a_busy;
  logic [33:0] a_da, a_oa;
  logic [19:0] a_dl;
  logic [7:0]  a_dt, a_oid;
  logic [1:0]  a_os;
  logic        b_sr, b_lr, b_dv, b_ov, b_op, b_busy;
  logic [33:0] b_da, b_oa;
  logic [19:0] b_dl;
  logic [7:0]  b_dt, b_oid;
  logic [1:0]  b_os;

  logic        store_ready, load_ready, desc_valid, done_valid, done_op, busy;
  logic [33:0] desc_addr, done_addr;
  logic [19:0] desc_len;
  logic [7:0]  desc_tag, done_id;
  logic [1:0]  done_status;

  assign store_ready = sel ? b_sr : a_sr;
  assign load_ready  = sel ? b_lr : a_lr;
  assign desc_valid  = sel ? b_dv : a_dv;
  assign desc_addr   = sel ? b_da : a_da;
  assign desc_len    = sel ? b_dl : a_dl;
  assign desc_tag    = sel ? b_dt : a_dt;
  assign done_valid  = sel ? b_ov : a_ov;
  assign done_op     = sel ? b_op : a_op;
  assign done_id     = sel ? b_oid : a_oid;
  assign done_status = sel ? b_os : a_os;
  assign done_addr   = sel ? b_oa : a_oa;
  assign busy        = sel ? b_busy : a_busy;

  recon_load_scheduler dut_a (
    .clk(clk), .rst_n(rst_n),
    .store_req_valid(store_req_valid), .store_req_ready(a_sr),
    .store_id(store_id), .store_size(store_size),
    .load_req_valid(load_req_valid), .load_req_ready(a_lr), .load_id(load_id),
    .m_axis_read_desc_addr(a_da), .m_axis_read_desc_len(a_dl),
    .m_axis_read_desc_tag(a_dt), .m_axis_read_desc_valid(a_dv),
    .m_axis_read_desc_ready(desc_ready),
    .s_axis_read_desc_status_tag(st_tag), .s_axis_read_desc_status_error(st_err),
    .s_axis_read_desc_status_valid(st_valid),
    .done_valid(a_ov), .done_op(a_op), .done_id(a_oid), .done_status(a_os),
    .done_addr(a_oa), .busy(a_busy)
  );

  recon_load_scheduler #(.REGION_SIZE(64'h4000), .MAX_OUTSTANDING(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .store_req_valid(store_req_valid), .store_req_ready(b_sr),
    .store_id(store_id), .store_size(store_size),
    .load_req_valid(load_req_valid), .load_req_ready(b_lr), .load_id(load_id),
    .m_axis_read_desc_addr(b_da), .m_axis_read_desc_len(b_dl),
    .m_axis_read_desc_tag(b_dt), .m_axis_read_desc_valid(b_dv),
    .m_axis_read_desc_ready(desc_ready),
    .s_axis_read_desc_status_tag(st_tag), .s_axis_read_desc_status_error(st_err),
    .s_axis_read_desc_status_valid(st_valid),
    .done_valid(b_ov), .done_op(b_op), .done_id(b_oid), .done_status(b_os),
    .done_addr(b_oa), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumers: one expected record per descriptor handshake / done pulse
  always @(negedge clk) begin
    desc_t ed;
    done_t eo;
    if (rst_n && desc_valid && desc_ready) begin
      if (dq.size() == 0) check("desc_unexpected_count", 64'(dq.size()), 64'd1);
      else begin
        ed = dq.pop_front();
        check("desc_addr", 64'(desc_addr), 64'(ed.addr));
        check("desc_len", 64'(desc_len), 64'(ed.len));
        check("desc_tag", 64'(desc_tag), 64'(ed.tag));
        if (ed.cyc >= 0) check("desc_cycle", 64'(cyc), 64'(ed.cyc));
      end
    end
    if (rst_n && done_valid) begin
      if (oq.size() == 0) check("done_unexpected_count", 64'(oq.size()), 64'd1);
      else begin
        eo = oq.pop_front();
        check("done_op", 64'(done_op), 64'(eo.op));
        check("done_id", 64'(done_id), 64'(eo.id));
        check("done_status", 64'(done_status), 64'(eo.status));
        if (eo.chk_addr) check("done_addr", 64'(done_addr), 64'(eo.addr));
        if (eo.cyc >= 0) check("done_cycle", 64'(cyc), 64'(eo.cyc));
      end
    end
  end

  task automatic push_desc(input logic [33:0] a, input logic [19:0] l, input logic [7:0] t, input int c);
    desc_t d;
    d.addr = a; d.len = l; d.tag = t; d.cyc = c;
    dq.push_back(d);
  endtask

  task automatic push_done(input logic op, input logic [7:0] id, input logic [1:0] st,
                           input logic [33:0] a, input logic ca, input int c);
    done_t d;
    d.op = op; d.id = id; d.status = st; d.addr = a; d.chk_addr = ca; d.cyc = c;
    oq.push_back(d);
  endtask

  task automatic req(input logic is_load, input logic [7:0] id, input logic [31:0] sz, output int acc);
    acc = -1;
    if (is_load) begin
      load_req_valid = 1'b1; load_id = id;
    end else begin
      store_req_valid = 1'b1; store_id = id; store_size = sz;
    end
    for (int i = 0; i < 40 && acc < 0; i++) begin
      @(negedge clk);
      if (is_load ? load_ready : store_ready) acc = cyc;
      @(posedge clk); #1;
    end
    store_req_valid = 1'b0;
    load_req_valid  = 1'b0;
    check("req_accepted", 64'(acc >= 0), 64'd1);
  endtask

  task automatic wait_desc(input int budget);
    int n = 0;
    while (dq.size() != 0 && n < budget) begin @(negedge clk); n++; end
    check("desc_drain", 64'(dq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((dq.size() != 0 || oq.size() != 0) && n < budget) begin @(negedge clk); n++; end
    check("scoreboard_drain", 64'(dq.size() + oq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic status(input logic [7:0] t, input logic [3:0] e);
    st_valid = 1'b1; st_tag = t; st_err = e;
    @(posedge clk); #1;
    st_valid = 1'b0; st_err = '0;
  endtask

  task automatic do_reset(input logic s);
    rst_n = 1'b0; sel = s;
    dq.delete(); oq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, acc2, n;
    #1 rst_n = 1'b0;
    #2;
    check("rst_readies", 64'({store_ready, load_ready}), 64'd0);
    check("rst_valids", 64'({desc_valid, done_valid, busy}), 64'd0);
    check("rst_desc", 64'({desc_addr, desc_len, desc_tag}), 64'd0);
    check("rst_done", 64'({done_op, done_id, done_status, done_addr}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Stores allocate 4 KiB-aligned space from the region base
    desc_ready = 1'b1;
    req(1'b0, 8'd3, 32'd5000, acc);
    check("busy_active", 64'(busy), 64'd1);
    push_done(1'b0, 8'd3, 2'd0, 34'h0, 1'b1, acc + 2);
    drain(20);
    req(1'b0, 8'd4, 32'd100, acc);
    push_done(1'b0, 8'd4, 2'd0, 34'h2000, 1'b1, acc + 2);
    drain(20);
    check("busy_idle", 64'(busy), 64'd0);

    // Load split into two chunks with ready always high
    do_reset(1'b0);
    req(1'b0, 8'd3, 32'd5000, acc);
    push_done(1'b0, 8'd3, 2'd0, 34'h0, 1'b1, acc + 2);
    drain(20);
    desc_ready = 1'b1;
    req(1'b1, 8'd3, 32'd0, acc);
    push_desc(34'h0, 20'd4096, 8'd0, acc + 2);
    push_desc(34'h1000, 20'd904, 8'd1, acc + 3);
    push_done(1'b1, 8'd3, 2'd0, 34'h0, 1'b1, -1);
    wait_desc(20);
    status(8'd0, 4'd0);
    status(8'd1, 4'd0);
    drain(20);

    // One outstanding descriptor, delayed completions, second one errors
    do_reset(1'b1);
    req(1'b0, 8'd3, 32'd5000, acc);
    push_done(1'b0, 8'd3, 2'd0, 34'h0, 1'b1, acc + 2);
    drain(20);
    req(1'b1, 8'd3, 32'd0, acc);
    push_desc(34'h0, 20'd4096, 8'd0, acc + 2);
    wait_desc(20);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("desc_blocked", 64'(desc_valid), 64'd0);
    @(posedge clk); #1;
    push_desc(34'h1000, 20'd904, 8'd1, -1);
    status(8'd0, 4'd0);
    wait_desc(20);
    repeat (9) @(posedge clk);
    #1;
    push_done(1'b1, 8'd3, 2'd3, 34'h0, 1'b1, -1);
    status(8'd1, 4'h2);
    drain(20);

    // Lookup failure, bad id, zero size
    do_reset(1'b0);
    desc_ready = 1'b1;
    req(1'b1, 8'd7, 32'd0, acc);
    push_done(1'b1, 8'd7, 2'd2, 34'h0, 1'b0, acc + 2);
    drain(20);
    req(1'b0, 8'd20, 32'd64, acc);
    push_done(1'b0, 8'd20, 2'd1, 34'h0, 1'b0, acc + 2);
    drain(20);
    req(1'b0, 8'd5, 32'd0, acc);
    push_done(1'b0, 8'd5, 2'd3, 34'h0, 1'b0, acc + 2);
    drain(20);

    // 16 KiB region: exhaustion, in-place reuse, exact fill
    do_reset(1'b1);
    desc_ready = 1'b1;
    req(1'b0, 8'd1, 32'h3000, acc);
    push_done(1'b0, 8'd1, 2'd0, 34'h0, 1'b1, acc + 2);
    drain(20);
    req(1'b0, 8'd2, 32'h2000, acc);
    push_done(1'b0, 8'd2, 2'd2, 34'h0, 1'b0, acc + 2);
    drain(20);
    req(1'b0, 8'd1, 32'h1000, acc);
    push_done(1'b0, 8'd1, 2'd0, 34'h0, 1'b1, acc + 2);
    drain(20);
    req(1'b0, 8'd2, 32'h1000, acc);
    push_done(1'b0, 8'd2, 2'd0, 34'h3000, 1'b1, acc + 2);
    drain(20);
    req(1'b1, 8'd1, 32'd0, acc);
    push_desc(34'h0, 20'd4096, 8'd0, acc + 2);
    push_done(1'b1, 8'd1, 2'd0, 34'h0, 1'b1, -1);
    wait_desc(20);
    status(8'd0, 4'd0);
    drain(20);

    // Simultaneous requests from reset: store first, then load
    do_reset(1'b0);
    desc_ready = 1'b1;
    store_req_valid = 1'b1; store_id = 8'd9; store_size = 32'd10;
    load_req_valid = 1'b1;  load_id = 8'd9;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk);
      if (store_ready || load_ready) begin
        acc = cyc;
        check("tie_grant", 64'({store_ready, load_ready}), 64'b10);
      end
      @(posedge clk); #1;
    end
    store_req_valid = 1'b0;
    check("tie_seen", 64'(acc >= 0), 64'd1);
    push_done(1'b0, 8'd9, 2'd0, 34'h0, 1'b1, acc + 2);
    acc2 = -1;
    for (int i = 0; i < 20 && acc2 < 0; i++) begin
      @(negedge clk);
      if (load_ready) acc2 = cyc;
      @(posedge clk); #1;
    end
    load_req_valid = 1'b0;
    check("load_after_store", 64'(acc2 > acc), 64'd1);
    push_desc(34'h0, 20'd10, 8'd0, acc2 + 2);
    push_done(1'b1, 8'd9, 2'd0, 34'h0, 1'b1, -1);
    wait_desc(20);
    status(8'd0, 4'd0);
    drain(20);

    // Reset during descriptor issue
    do_reset(1'b0);
    req(1'b0, 8'd3, 32'd5000, acc);
    push_done(1'b0, 8'd3, 2'd0, 34'h0, 1'b1, acc + 2);
    drain(20);
    desc_ready = 1'b0;
    req(1'b1, 8'd3, 32'd0, acc);
    n = 0;
    while (!desc_valid && n < 10) begin @(negedge clk); n++; end
    check("desc_pending", 64'(desc_valid), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_desc_valid", 64'(desc_valid), 64'd0);
    check("rst_mid_busy", 64'({busy, done_valid}), 64'd0);
    dq.delete(); oq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    status(8'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("stale_status_idle", 64'(busy), 64'd0);
    desc_ready = 1'b1;
    req(1'b1, 8'd3, 32'd0, acc);
    push_done(1'b1, 8'd3, 2'd2, 34'h0, 1'b0, acc + 2);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
